// File: rtl/sobel_window_gen_pkg.sv
// Shared definitions for the Sobel path: pixel format, RGB565 field slices
// and default image geometry. Also used by the Sobel core and VGA blocks.
package sobel_window_gen_pkg;

  // Pixel width and RGB565 field positions
  localparam int WORD_SIZE = 16;
  localparam int RED_HI    = 15;
  localparam int RED_LO    = 11;
  localparam int GREEN_HI  = 10;
  localparam int GREEN_LO  = 5;
  localparam int BLUE_HI   = 4;
  localparam int BLUE_LO   = 0;

  // Default active image geometry and the counter widths that cover it
  localparam int IMAGE_WIDTH  = 640;
  localparam int IMAGE_HEIGHT = 480;
  localparam int X_WIDTH      = 10;
  localparam int Y_WIDTH      = 9;

  // A 3x3 window has nine taps, numbered row-major from the top-left
  localparam int WINDOW_TAPS  = 9;

  // Green channel of an RGB565 word, zero-extended to 8 bits
  function automatic logic [7:0] rgb565_green(input logic [WORD_SIZE-1:0] px);
    return {2'b00, px[GREEN_HI:GREEN_LO]};
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixel storage. Single shared address: the read returns
// the old contents combinationally while the write of the same entry takes
// effect at the clock edge, giving read-before-write behaviour.
// Contents are never reset; they are don't-care until rewritten.
module sobel_line_buffer #(
  parameter int Depth     = 640,
  parameter int Width     = 16,
  parameter int AddrWidth = 10
) (
  input  logic                 clk,
  input  logic [AddrWidth-1:0] i_addr,
  input  logic                 i_wr_en,
  input  logic [Width-1:0]     i_wr_data,
  output logic [Width-1:0]     o_rd_data
);

  logic [Width-1:0] r_mem [0:Depth-1];

  // Old value at the addressed column, before any write this cycle
  assign o_rd_data = r_mem[i_addr];

  // Store the new value when the pixel stream advances
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_addr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-to-window front end for the Sobel path. Accepts one pixel per valid
// cycle in raster order, keeps the two previous lines in line buffers and
// presents a registered 3x3 neighbourhood with a one-cycle valid strobe and
// the coordinates of the window centre.
//
// Stream semantics: pixel_in/frame_start are consumed on every rising edge
// where pixel_valid is high; there is no back-pressure. frame_start only has
// effect on such an edge and forces that pixel to be (0,0). window_valid is a
// single-cycle strobe following the accepting edge; sliding0..8 are stable
// until the next accepted pixel, out_x/out_y until the next valid window.
module sobel_window_gen
  import sobel_window_gen_pkg::*;
#(
  parameter int WordSize    = WORD_SIZE,
  parameter int ImageWidth  = IMAGE_WIDTH,
  parameter int ImageHeight = IMAGE_HEIGHT,
  parameter int XWidth      = X_WIDTH,
  parameter int YWidth      = Y_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WordSize-1:0] pixel_in,
  input  logic                pixel_valid,
  input  logic                frame_start,
  output logic [WordSize-1:0] sliding0,
  output logic [WordSize-1:0] sliding1,
  output logic [WordSize-1:0] sliding2,
  output logic [WordSize-1:0] sliding3,
  output logic [WordSize-1:0] sliding4,
  output logic [WordSize-1:0] sliding5,
  output logic [WordSize-1:0] sliding6,
  output logic [WordSize-1:0] sliding7,
  output logic [WordSize-1:0] sliding8,
  output logic                window_valid,
  output logic [XWidth-1:0]   out_x,
  output logic [YWidth-1:0]   out_y
);

  localparam logic [XWidth-1:0] LastCol = XWidth'(ImageWidth - 1);
  localparam logic [YWidth-1:0] LastRow = YWidth'(ImageHeight - 1);
  localparam logic [XWidth-1:0] MinCol  = XWidth'(2);
  localparam logic [YWidth-1:0] MinRow  = YWidth'(2);

  // Raster position of the next pixel to be accepted
  logic [XWidth-1:0] r_col;
  logic [YWidth-1:0] r_row;

  // Registered window, row-major: 0..2 oldest line, 6..8 newest line
  logic [WordSize-1:0] r_win [0:WINDOW_TAPS-1];
  logic                r_window_valid;
  logic [XWidth-1:0]   r_out_x;
  logic [YWidth-1:0]   r_out_y;

  // Effective position of the current pixel; frame_start forces (0,0)
  logic [XWidth-1:0]   w_c;
  logic [YWidth-1:0]   w_r;
  logic                w_last_col;
  logic                w_last_row;
  logic                w_full_window;
  logic [WordSize-1:0] w_lb0_rd;   // line r-1 at column c
  logic [WordSize-1:0] w_lb1_rd;   // line r-2 at column c

  // Resolve where the incoming pixel lands and whether its window is complete
  always_comb begin
    w_c           = frame_start ? '0 : r_col;
    w_r           = frame_start ? '0 : r_row;
    w_last_col    = (w_c == LastCol);
    w_last_row    = (w_r == LastRow);
    w_full_window = (w_c >= MinCol) && (w_r >= MinRow);
  end

  // Previous line: written with the incoming pixel
  sobel_line_buffer #(
    .Depth     (ImageWidth),
    .Width     (WordSize),
    .AddrWidth (XWidth)
  ) u_linebuf0 (
    .clk       (clk),
    .i_addr    (w_c),
    .i_wr_en   (pixel_valid),
    .i_wr_data (pixel_in),
    .o_rd_data (w_lb0_rd)
  );

  // Line before that: written with the value displaced from linebuf0
  sobel_line_buffer #(
    .Depth     (ImageWidth),
    .Width     (WordSize),
    .AddrWidth (XWidth)
  ) u_linebuf1 (
    .clk       (clk),
    .i_addr    (w_c),
    .i_wr_en   (pixel_valid),
    .i_wr_data (w_lb0_rd),
    .o_rd_data (w_lb1_rd)
  );

  // Raster counters: advance per accepted pixel, wrap at line and frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (pixel_valid) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : w_r + 1'b1;
      end else begin
        r_col <= w_c + 1'b1;
        r_row <= w_r;
      end
    end
  end

  // Window shift: each row moves left, the new column enters on the right
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WINDOW_TAPS; i++) begin
        r_win[i] <= '0;
      end
    end else if (pixel_valid) begin
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= w_lb1_rd;
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= w_lb0_rd;
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= pixel_in;
    end
  end

  // Valid strobe and centre coordinates; coordinates hold between windows
  always_ff @(posedge clk) begin
    if (rst) begin
      r_window_valid <= 1'b0;
      r_out_x        <= '0;
      r_out_y        <= '0;
    end else begin
      r_window_valid <= pixel_valid && w_full_window;
      if (pixel_valid && w_full_window) begin
        r_out_x <= w_c - 1'b1;
        r_out_y <= w_r - 1'b1;
      end
    end
  end

  assign sliding0     = r_win[0];
  assign sliding1     = r_win[1];
  assign sliding2     = r_win[2];
  assign sliding3     = r_win[3];
  assign sliding4     = r_win[4];
  assign sliding5     = r_win[5];
  assign sliding6     = r_win[6];
  assign sliding7     = r_win[7];
  assign sliding8     = r_win[8];
  assign window_valid = r_window_valid;
  assign out_x        = r_out_x;
  assign out_y        = r_out_y;

endmodule
